// File: rtl/input_memory_reader.sv
// input_memory_reader: operand-feed stage of the sum-stationary matrix-multiply
// datapath. Fetches N-element vectors from operand memory, P words per access,
// and streams each assembled vector to the processing array, then reports
// completion to the controller.
module input_memory_reader #(
  parameter int INPUT_DATA_WIDTH               = 8,
  parameter int B_N                            = 2,
  parameter int N                              = 1 << B_N,
  parameter int ADDRESS_WIDTH                  = 6,
  parameter int B_PARALLEL_DATA_STREAMING_SIZE = 2,
  parameter int PARALLEL_DATA_STREAMING_SIZE   = 1 << B_PARALLEL_DATA_STREAMING_SIZE,
  parameter int MAX_MATRIX_LENGTH              = 16,
  parameter int LENGTH_BITS                    = $clog2(MAX_MATRIX_LENGTH + 1)
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   instruction_valid,
  output logic                                                   instruction_ready,
  input  logic [ADDRESS_WIDTH-1:0]                               address_input,
  input  logic [LENGTH_BITS-1:0]                                 length_input,
  input  logic                                                   input_by_row_instruction,
  output logic                                                   completed_valid,
  input  logic                                                   completed_ready,
  output logic                                                   read_valid,
  input  logic                                                   read_ready,
  output logic [ADDRESS_WIDTH-1:0]                               read_address,
  input  logic [PARALLEL_DATA_STREAMING_SIZE-1:0][INPUT_DATA_WIDTH-1:0] read_data,
  output logic                                                   data_valid,
  input  logic                                                   data_ready,
  output logic                                                   data_by_row,
  output logic [N-1:0][INPUT_DATA_WIDTH-1:0]                     data_streaming
);

  localparam int P    = PARALLEL_DATA_STREAMING_SIZE;
  localparam int WC_W = (B_N > 0) ? B_N : 1;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t                               state;
  logic [LENGTH_BITS-1:0]               length_reg;
  logic [LENGTH_BITS-1:0]               vector_index;
  logic [WC_W-1:0]                      word_counter;
  logic                                 by_row_reg;
  logic [N-1:0][INPUT_DATA_WIDTH-1:0]   buffer;
  logic                                 last_word;
  logic                                 last_vector;

  // The buffer only changes in FETCH, so it can feed the array directly.
  assign data_streaming = buffer;
  assign data_by_row    = by_row_reg;

  assign last_word   = (word_counter == WC_W'(N - P));
  assign last_vector = (vector_index == (length_reg - LENGTH_BITS'(1)));

  // Control FSM with registered handshake outputs. The read address walks
  // contiguously by P, which equals base + vector_index*N + word_counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      instruction_ready <= 1'b1;
      read_valid        <= 1'b0;
      data_valid        <= 1'b0;
      completed_valid   <= 1'b0;
      read_address      <= '0;
      by_row_reg        <= 1'b0;
      length_reg        <= '0;
      vector_index      <= '0;
      word_counter      <= '0;
      buffer            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instruction_valid) begin
            length_reg        <= length_input;
            by_row_reg        <= input_by_row_instruction;
            read_address      <= address_input;
            vector_index      <= '0;
            word_counter      <= '0;
            instruction_ready <= 1'b0;
            if (length_input == '0) begin
              state           <= DONE;
              completed_valid <= 1'b1;
            end else begin
              state      <= FETCH;
              read_valid <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (read_ready) begin
            for (int i = 0; i < P; i++) begin
              buffer[word_counter + WC_W'(i)] <= read_data[i];
            end
            read_address <= read_address + ADDRESS_WIDTH'(P);
            if (last_word) begin
              word_counter <= '0;
              read_valid   <= 1'b0;
              data_valid   <= 1'b1;
              state        <= SEND;
            end else begin
              word_counter <= word_counter + WC_W'(P);
            end
          end
        end
        SEND: begin
          if (data_ready) begin
            data_valid <= 1'b0;
            if (last_vector) begin
              state           <= DONE;
              completed_valid <= 1'b1;
            end else begin
              vector_index <= vector_index + LENGTH_BITS'(1);
              read_valid   <= 1'b1;
              state        <= FETCH;
            end
          end
        end
        DONE: begin
          if (completed_ready) begin
            completed_valid   <= 1'b0;
            instruction_ready <= 1'b1;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_memory_reader.sv
// Scoreboard bench for input_memory_reader: a P=4 instance for most cases and
// a P=2 instance for the partial-width fetch with address wrap.
module tb_input_memory_reader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // DUT A: N=4, P=4
  logic            instruction_valid, instruction_ready;
  logic [5:0]      address_input;
  logic [4:0]      length_input;
  logic            input_by_row_instruction;
  logic            completed_valid, completed_ready;
  logic            read_valid, read_ready;
  logic [5:0]      read_address;
  logic [3:0][7:0] read_data;
  logic            data_valid, data_ready, data_by_row;
  logic [3:0][7:0] data_streaming;

  // DUT B: N=4, P=2
  logic            b_instruction_valid, b_instruction_ready;
  logic [5:0]      b_address_input;
  logic [4:0]      b_length_input;
  logic            b_completed_valid;
  logic            b_read_valid;
  logic [5:0]      b_read_address;
  logic [3:0][7:0] b_full;
  logic [1:0][7:0] b_read_data;
  logic            b_data_valid, b_data_by_row;
  logic [3:0][7:0] b_data_streaming;

  input_memory_reader dut (
    .clk(clk), .reset(reset),
    .instruction_valid(instruction_valid), .instruction_ready(instruction_ready),
    .address_input(address_input), .length_input(length_input),
    .input_by_row_instruction(input_by_row_instruction),
    .completed_valid(completed_valid), .completed_ready(completed_ready),
    .read_valid(read_valid), .read_ready(read_ready),
    .read_address(read_address), .read_data(read_data),
    .data_valid(data_valid), .data_ready(data_ready),
    .data_by_row(data_by_row), .data_streaming(data_streaming)
  );

  input_memory_reader #(.B_PARALLEL_DATA_STREAMING_SIZE(1)) dut_b (
    .clk(clk), .reset(reset),
    .instruction_valid(b_instruction_valid), .instruction_ready(b_instruction_ready),
    .address_input(b_address_input), .length_input(b_length_input),
    .input_by_row_instruction(1'b1),
    .completed_valid(b_completed_valid), .completed_ready(1'b1),
    .read_valid(b_read_valid), .read_ready(1'b1),
    .read_address(b_read_address), .read_data(b_read_data),
    .data_valid(b_data_valid), .data_ready(1'b1),
    .data_by_row(b_data_by_row), .data_streaming(b_data_streaming)
  );

  // Memory model: memory[a] = a, zero-latency, addresses wrap at 64.
  function automatic logic [3:0][7:0] mem_rd(input logic [5:0] addr);
    logic [3:0][7:0] r;
    for (int i = 0; i < 4; i++) r[i] = {2'b00, 6'(addr + 6'(i))};
    return r;
  endfunction

  function automatic logic [31:0] vec_of(input logic [5:0] start);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = {2'b00, 6'(start + 6'(k))};
    return v;
  endfunction

  assign read_data   = mem_rd(read_address);
  assign b_full      = mem_rd(b_read_address);
  assign b_read_data = b_full[1:0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    tests++;
    fails++;
    $display("FAIL %s: unexpected DUT event at %0t", name, $time);
  endtask

  // Scoreboard queues
  logic [5:0]  qa[$];
  logic [32:0] qd[$];
  bit          qc[$];
  logic [5:0]  qa2[$];
  logic [32:0] qd2[$];

  // Monitor for DUT A
  always @(negedge clk) begin
    if (!reset) begin
      if (read_valid && read_ready) begin
        if (qa.size() == 0) fail_evt("read_unexpected");
        else chk("read_address", 64'(read_address), 64'(qa.pop_front()));
      end
      if (data_valid && data_ready) begin
        if (qd.size() == 0) fail_evt("data_unexpected");
        else chk("vector", 64'({data_by_row, data_streaming}), 64'(qd.pop_front()));
      end
      if (completed_valid && completed_ready) begin
        if (qc.size() == 0) fail_evt("completion_unexpected");
        else void'(qc.pop_front());
      end
    end
  end

  // Monitor for DUT B
  always @(negedge clk) begin
    if (!reset) begin
      if (b_read_valid) begin
        if (qa2.size() == 0) fail_evt("b_read_unexpected");
        else chk("b_read_address", 64'(b_read_address), 64'(qa2.pop_front()));
      end
      if (b_data_valid) begin
        if (qd2.size() == 0) fail_evt("b_data_unexpected");
        else chk("b_vector", 64'({b_data_by_row, b_data_streaming}), 64'(qd2.pop_front()));
      end
    end
  end

  task automatic issue(input logic [5:0] addr, input logic [4:0] len, input logic row);
    instruction_valid        = 1'b1;
    address_input            = addr;
    length_input             = len;
    input_by_row_instruction = row;
    @(posedge clk); #1;
    instruction_valid = 1'b0;
  endtask

  task automatic send_instr(input logic [5:0] addr, input logic [4:0] len, input logic row);
    for (int v = 0; v < int'(len); v++) begin
      qa.push_back(6'(addr + 6'(v * 4)));
      qd.push_back({row, vec_of(6'(addr + 6'(v * 4)))});
    end
    qc.push_back(1'b1);
    issue(addr, len, row);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(instruction_ready && qa.size() == 0 && qd.size() == 0 && qc.size() == 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_a", 64'(n < 300), 64'd1);
  endtask

  task automatic check_reset_values();
    chk("rst_instruction_ready", 64'(instruction_ready), 64'd1);
    chk("rst_read_valid", 64'(read_valid), 64'd0);
    chk("rst_data_valid", 64'(data_valid), 64'd0);
    chk("rst_completed_valid", 64'(completed_valid), 64'd0);
    chk("rst_read_address", 64'(read_address), 64'd0);
    chk("rst_data_by_row", 64'(data_by_row), 64'd0);
    chk("rst_data_streaming", 64'(data_streaming), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] snap;
    int n;
    reset = 1'b1;
    instruction_valid = 1'b0; address_input = '0; length_input = '0;
    input_by_row_instruction = 1'b0;
    completed_ready = 1'b1; read_ready = 1'b1; data_ready = 1'b1;
    b_instruction_valid = 1'b0; b_address_input = '0; b_length_input = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_values();
    chk("b_rst_instruction_ready", 64'(b_instruction_ready), 64'd1);

    // Basic transfer
    send_instr(6'h10, 5'd2, 1'b1);
    chk("read_valid_after_accept", 64'(read_valid), 64'd1);
    chk("instruction_ready_busy", 64'(instruction_ready), 64'd0);
    wait_idle();

    // Partial-width fetch with wrap on the P=2 instance
    qa2.push_back(6'h3C); qa2.push_back(6'h3E); qa2.push_back(6'h00); qa2.push_back(6'h02);
    qd2.push_back({1'b1, vec_of(6'h3C)}); qd2.push_back({1'b1, vec_of(6'h00)});
    b_instruction_valid = 1'b1; b_address_input = 6'h3C; b_length_input = 5'd2;
    @(posedge clk); #1;
    b_instruction_valid = 1'b0;
    n = 0;
    while (!(b_instruction_ready && qa2.size() == 0 && qd2.size() == 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_b", 64'(n < 300), 64'd1);

    // Processor backpressure
    data_ready = 1'b0;
    send_instr(6'h05, 5'd1, 1'b0);
    n = 0;
    while (!data_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_data_valid_seen", 64'(data_valid), 64'd1);
    snap = data_streaming;
    for (int c = 0; c < 5; c++) begin
      chk("bp_data_valid_hold", 64'(data_valid), 64'd1);
      chk("bp_data_stable", 64'(data_streaming), 64'(snap));
      chk("bp_read_valid_low", 64'(read_valid), 64'd0);
      @(posedge clk); #1;
    end
    data_ready = 1'b1;
    wait_idle();

    // Memory stall on the second vector's fetch
    send_instr(6'h30, 5'd3, 1'b1);
    n = 0;
    while (!(read_valid && read_address == 6'h34) && n < 50) begin @(posedge clk); #1; n++; end
    read_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("stall_read_valid", 64'(read_valid), 64'd1);
      chk("stall_read_address", 64'(read_address), 64'h34);
      chk("stall_data_valid", 64'(data_valid), 64'd0);
    end
    read_ready = 1'b1;
    wait_idle();

    // Zero length, with held completion and an ignored instruction
    completed_ready = 1'b0;
    send_instr(6'h00, 5'd0, 1'b0);
    chk("zl_completed_valid", 64'(completed_valid), 64'd1);
    chk("zl_read_valid", 64'(read_valid), 64'd0);
    chk("zl_instruction_ready", 64'(instruction_ready), 64'd0);
    instruction_valid = 1'b1; address_input = 6'h11; length_input = 5'd1;
    @(posedge clk); #1;
    instruction_valid = 1'b0;
    chk("zl_completed_hold", 64'(completed_valid), 64'd1);
    chk("zl_ignored_no_read", 64'(read_valid), 64'd0);
    completed_ready = 1'b1;
    @(posedge clk); #1;
    chk("zl_ready_returns", 64'(instruction_ready), 64'd1);
    chk("zl_completed_clear", 64'(completed_valid), 64'd0);
    chk("zl_queue_drained", 64'(qc.size()), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("ignored_instr_no_read", 64'(read_valid), 64'd0);

    // Reset mid-FETCH: first vector goes through, reset during the second fetch
    qa.push_back(6'h08);
    qd.push_back({1'b1, vec_of(6'h08)});
    issue(6'h08, 5'd2, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_fetch_read_valid", 64'(read_valid), 64'd1);
    read_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_values();
    reset = 1'b0;
    read_ready = 1'b1;
    @(posedge clk); #1;
    send_instr(6'h20, 5'd1, 1'b1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/input_memory_reader.md
# input_memory_reader

Upstream operand-feed stage of the sum-stationary matrix-multiply datapath. It accepts a read instruction from the controller (base address, vector count, row/column orientation) and fetches N-element vectors from operand memory, PARALLEL_DATA_STREAMING_SIZE words per access. It streams each assembled vector to the processing array over a valid/ready interface, then reports completion to the controller through a handshake. It is the input-side counterpart of the output memory writer.

## Interface

Parameters:
- INPUT_DATA_WIDTH, 8, width of one operand element.
- B_N, 2, log2 of array width.
- N, 1 << B_N, elements per vector.
- ADDRESS_WIDTH, 6, memory word-address width.
- B_PARALLEL_DATA_STREAMING_SIZE, 2, log2 of words per memory access.
- PARALLEL_DATA_STREAMING_SIZE (P), 1 << B_PARALLEL_DATA_STREAMING_SIZE, words per access; must divide N.
- MAX_MATRIX_LENGTH, 16, maximum vectors per instruction.
- LENGTH_BITS, $clog2(MAX_MATRIX_LENGTH + 1), width of the vector count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- instruction_valid  in  1  controller instruction valid.
- instruction_ready  out  1  block can accept an instruction.
- address_input  in  ADDRESS_WIDTH  base word address.
- length_input  in  LENGTH_BITS  number of vectors, 0..MAX_MATRIX_LENGTH.
- input_by_row_instruction  in  1  1 = row-wise feed, 0 = column-wise feed.
- completed_valid  out  1  instruction finished.
- completed_ready  in  1  controller acknowledges completion.
- read_valid  out  1  memory read request.
- read_ready  in  1  memory accepts the request; read_data is valid in the same cycle (zero latency).
- read_address  out  ADDRESS_WIDTH  request address.
- read_data  in  INPUT_DATA_WIDTH x P  returned words.
- data_valid  out  1  vector available to the processor.
- data_ready  in  1  processor consumes the vector.
- data_by_row  out  1  latched orientation.
- data_streaming  out  INPUT_DATA_WIDTH x N  assembled vector.

## Operation

- The FSM has four states: IDLE, FETCH, SEND, DONE. Reset enters IDLE.
- IDLE
  - instruction_ready = 1.
  - On instruction handshake, latch address, length and orientation, and clear vector_index and word_counter.
  - If length = 0, go to DONE; otherwise go to FETCH.
- FETCH
  - read_valid = 1.
  - read_address = base + vector_index*N + word_counter, truncated to ADDRESS_WIDTH (wraps modulo 2^ADDRESS_WIDTH).
  - On read handshake, store buffer[word_counter+i] <= read_data[i] for i in 0..P-1.
  - If word_counter = N-P, clear word_counter and go to SEND; otherwise word_counter += P.
- SEND
  - data_valid = 1 and data_streaming = buffer.
  - On data handshake: if vector_index = length-1, go to DONE; otherwise increment vector_index and go to FETCH.
- DONE
  - completed_valid = 1.
  - On completion handshake, go to IDLE.
- data_by_row always drives the latched orientation register.
- Outputs that are deasserted in a state are 0: read_valid, data_valid, completed_valid, and instruction_ready outside IDLE.
- Reset values:
  - state IDLE, instruction_ready = 1.
  - read_valid, data_valid, completed_valid = 0.
  - read_address = 0, data_by_row = 0.
  - buffer and data_streaming = all zeros.
  - All counters = 0.
- Reset at any point, mid-operation included, abandons the instruction with no completion pulse. An instruction may be accepted the cycle after reset deasserts.

## Timing

- All state changes occur on the posedge of clk. Handshakes complete on the posedge where valid and ready are both high.
- Instruction accepted at edge t: read_valid is high in cycle t+1 (or completed_valid, if length = 0).
- Minimum cost per vector is N/P fetch cycles plus 1 send cycle.
- The last fetch handshake at edge f gives data_valid in cycle f+1.
- Data handshake at edge s: the next read_valid, or completed_valid, is high in cycle s+1.
- Completion handshake at edge c: instruction_ready is high in cycle c+1. The block never accepts an instruction while completed_valid is high.
- Stability rules:
  - While data_valid is high and data_ready is low, data_streaming and data_by_row hold.
  - While read_valid is high and read_ready is low, read_address holds and the buffer is unchanged.
  - While completed_valid is high and completed_ready is low, completed_valid holds.
- An instruction_valid that arrives outside IDLE is ignored; it is not queued.

## Test plan

- Basic transfer:
  - Stimulus: N=4, P=4, memory[a] = a, all readies 1; instruction addr 0x10, length 2.
  - Response: reads at 0x10, 0x14; vectors {0x10..0x13} then {0x14..0x17}; completed_valid one cycle after the second data handshake.
- Partial-width fetch with wrap:
  - Stimulus: P=2, addr 0x3C, length 2.
  - Response: read addresses 0x3C, 0x3E, 0x00, 0x02; vectors {0x3C..0x3F}, {0x00..0x03}.
- Processor backpressure:
  - Stimulus: data_ready low for 5 cycles in SEND.
  - Response: data_valid stays high, data_streaming is constant, read_valid stays 0; handshake on the 6th cycle.
- Memory stall:
  - Stimulus: read_ready low for 3 cycles mid-FETCH.
  - Response: read_address is constant; the final vector is correct.
- Zero length:
  - Stimulus: instruction with length 0.
  - Response: no read_valid; completed_valid in the next cycle; instruction_ready returns after completed_ready.
- Reset mid-FETCH:
  - Stimulus: reset asserted after the first read handshake.
  - Response: all outputs at reset values the next cycle; a new instruction (addr 0x20, length 1) completes correctly with vector {0x20..0x23}.
